// File: rtl/mcp3202_spi_responder.sv
// SPI slave standing in for the MCP3202 ADC: decodes start/SGL/ODD/MSBF,
// latches a channel or clamped difference, and shifts null + result out on MISO.
module mcp3202_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sck,
    input  logic        cs,
    input  logic        mosi,
    input  logic [11:0] ch0_data,
    input  logic [11:0] ch1_data,
    output logic        miso,
    output logic        miso_oe,
    output logic        cfg_sgl,
    output logic        cfg_odd,
    output logic        cfg_msbf,
    output logic        frame_done,
    output logic        frame_abort,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_CFG, S_NULL, S_MSB, S_LSB, S_DONE
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_armed;
    logic                   r_sgl;
    logic                   r_odd;
    logic [3:0]             r_cnt;
    logic [11:0]            r_sample;

    logic        w_sck;
    logic        w_cs;
    logic        w_mosi;
    logic        w_rise;
    logic        w_fall;
    logic [12:0] w_d01;
    logic [12:0] w_d10;
    logic [11:0] w_sample;

    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise = w_sck & ~r_sck_d;
    assign w_fall = ~w_sck & r_sck_d;

    // cs chain resets low so a cs held low through reset never looks like a new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sck_d     <= w_sck;
        end
    end

    // 13-bit differences: bit 12 set means negative, which clamps to zero
    assign w_d01 = {1'b0, ch0_data} - {1'b0, ch1_data};
    assign w_d10 = {1'b0, ch1_data} - {1'b0, ch0_data};

    always_comb begin
        w_sample = ch0_data;
        case ({r_sgl, r_odd})
            2'b11:   w_sample = ch1_data;
            2'b10:   w_sample = ch0_data;
            2'b00:   w_sample = w_d01[12] ? 12'h000 : w_d01[11:0];
            default: w_sample = w_d10[12] ? 12'h000 : w_d10[11:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_armed     <= 1'b0;
            r_sgl       <= 1'b0;
            r_odd       <= 1'b0;
            r_cnt       <= '0;
            r_sample    <= '0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            cfg_sgl     <= 1'b0;
            cfg_odd     <= 1'b0;
            cfg_msbf    <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            if (w_cs) r_armed <= 1'b1;

            if (r_state != S_IDLE && w_cs) begin
                r_state <= S_IDLE;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
                if (r_state == S_DONE) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                end else if (r_state != S_WAIT) begin
                    frame_abort <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        miso    <= 1'b0;
                        miso_oe <= 1'b0;
                        if (!w_cs && r_armed) r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (w_rise && w_mosi) begin
                            r_state <= S_CFG;
                            r_cnt   <= '0;
                        end
                    end
                    S_CFG: begin
                        if (w_rise) begin
                            r_cnt <= r_cnt + 4'd1;
                            case (r_cnt)
                                4'd0:    r_sgl <= w_mosi;
                                4'd1:    r_odd <= w_mosi;
                                default: begin
                                    cfg_sgl  <= r_sgl;
                                    cfg_odd  <= r_odd;
                                    cfg_msbf <= w_mosi;
                                    r_sample <= w_sample;
                                    r_state  <= S_NULL;
                                end
                            endcase
                        end
                    end
                    S_NULL: begin
                        if (w_fall) begin
                            miso_oe <= 1'b1;
                            miso    <= 1'b0;
                            r_cnt   <= 4'd11;
                            r_state <= S_MSB;
                        end
                    end
                    S_MSB: begin
                        if (w_fall) begin
                            miso <= r_sample[r_cnt];
                            if (r_cnt == 4'd0) begin
                                r_state <= cfg_msbf ? S_DONE : S_LSB;
                                r_cnt   <= 4'd1;
                            end else begin
                                r_cnt <= r_cnt - 4'd1;
                            end
                        end
                    end
                    S_LSB: begin
                        if (w_fall) begin
                            miso <= r_sample[r_cnt];
                            if (r_cnt == 4'd11) r_state <= S_DONE;
                            else                r_cnt   <= r_cnt + 4'd1;
                        end
                    end
                    S_DONE: begin
                        // last data bit holds through its low phase; the next fall parks MISO at 0
                        if (w_fall) miso <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcp3202_spi_responder.sv
// Directed bench: drives MCP3202-style frames and checks MISO against a value-level model.
`timescale 1ns/1ps
module tb_mcp3202_spi_responder;

    localparam int H = 10;  // SCK half period in clk cycles

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic [11:0] ch0_data = '0;
    logic [11:0] ch1_data = '0;
    logic        miso, miso_oe, cfg_sgl, cfg_odd, cfg_msbf, frame_done, frame_abort;
    logic [15:0] frame_cnt;

    mcp3202_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .cs(cs), .mosi(mosi),
        .ch0_data(ch0_data), .ch1_data(ch1_data),
        .miso(miso), .miso_oe(miso_oe),
        .cfg_sgl(cfg_sgl), .cfg_odd(cfg_odd), .cfg_msbf(cfg_msbf),
        .frame_done(frame_done), .frame_abort(frame_abort), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    bit    chk_en = 1'b0;
    bit    exp_miso = 1'b0;
    bit    exp_oe = 1'b0;
    int    req_id = 0;
    int    ack_id = 0;
    string r_name = "";
    int    r_act = 0;
    int    r_exp = 0;
    int    n_done = 0;
    int    n_abort = 0;
    int    exp_cnt = 0;

    // single compare process: serial stream while enabled, plus literal requests
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (miso !== exp_miso || miso_oe !== exp_oe) begin
                errors++;
                $display("FAIL miso_stream: got miso=%b oe=%b want miso=%b oe=%b at %0t",
                         miso, miso_oe, exp_miso, exp_oe, $time);
            end
        end
        if (req_id != ack_id) begin
            ack_id = req_id;
            checks++;
            if (r_act !== r_exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h want 0x%0h at %0t", r_name, r_act, r_exp, $time);
            end
        end
    end

    always @(negedge clk) begin
        if (frame_done)  n_done++;
        if (frame_abort) n_abort++;
    end

    function automatic int model(bit s, bit o, int c0, int c1);
        int d;
        if (s) return o ? c1 : c0;
        d = o ? (c1 - c0) : (c0 - c1);
        return (d < 0) ? 0 : d;
    endfunction

    task automatic lit(input string n, input int a, input int e);
        r_name = n; r_act = a; r_exp = e;
        req_id++;
        @(negedge clk); #1;
    endtask

    task automatic sck_cycle(input bit m, input bit em, input bit eo);
        mosi = m;
        repeat (H - 4) @(posedge clk);
        #1; exp_miso = em; exp_oe = eo; chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1; chk_en = 1'b0;
        sck = 1'b1;
        repeat (H) @(posedge clk);
        #1; sck = 1'b0;
    endtask

    task automatic frame(input int lead, input bit s, input bit o, input bit m, input int nsamp,
                         input bit chg, input logic [11:0] newch1, input bit end_cs);
        logic [11:0] v;
        bit          bits[24];
        int          dn0, ab0;
        bit          full;
        v = 12'(model(s, o, int'(ch0_data), int'(ch1_data)));
        bits[0] = 1'b0;
        for (int k = 0; k < 12; k++) bits[1 + k]  = v[11 - k];
        for (int k = 1; k < 12; k++) bits[12 + k] = v[k];
        full = m ? (nsamp >= 13) : (nsamp >= 24);
        cs = 1'b0;
        repeat (6) @(posedge clk); #1;
        repeat (lead) sck_cycle(1'b0, 1'b0, 1'b0);
        sck_cycle(1'b1, 1'b0, 1'b0);
        sck_cycle(s, 1'b0, 1'b0);
        sck_cycle(o, 1'b0, 1'b0);
        sck_cycle(m, 1'b0, 1'b0);
        if (chg) ch1_data = newch1;
        for (int i = 0; i < nsamp; i++) sck_cycle(1'b0, bits[i], 1'b1);
        if (end_cs) begin
            dn0 = n_done; ab0 = n_abort;
            repeat (4) @(posedge clk); #1;
            cs = 1'b1;
            repeat (3) @(posedge clk);
            @(negedge clk); #1;
            lit("oe_after_cs", int'(miso_oe), 0);
            lit("miso_after_cs", int'(miso), 0);
            repeat (6) @(posedge clk); #1;
            if (full) exp_cnt++;
            lit("done_pulses", n_done - dn0, full ? 1 : 0);
            lit("abort_pulses", n_abort - ab0, full ? 0 : 1);
            lit("frame_cnt", int'(frame_cnt), exp_cnt);
            lit("cfg_bits", int'({cfg_sgl, cfg_odd, cfg_msbf}), int'({s, o, m}));
        end
    endtask

    initial begin
        repeat (5) @(posedge clk); #1;
        lit("reset_outputs", int'({miso, miso_oe, cfg_sgl, cfg_odd, cfg_msbf, frame_done, frame_abort}), 0);
        lit("reset_frame_cnt", int'(frame_cnt), 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;

        lit("model_diff_clamp", model(1'b0, 1'b0, 'h100, 'h300), 'h000);
        lit("model_diff", model(1'b0, 1'b1, 'h100, 'h300), 'h200);

        // single-ended CH0, MSB first
        ch0_data = 12'hA5C; ch1_data = 12'h000;
        frame(0, 1'b1, 1'b0, 1'b1, 13, 1'b0, 12'h0, 1'b1);
        lit("frame_cnt_first", int'(frame_cnt), 1);

        // CH1, changed after the MSBF rise: readback stays 0x3FF
        ch1_data = 12'h3FF;
        frame(0, 1'b1, 1'b1, 1'b1, 13, 1'b1, 12'h000, 1'b1);

        // differential in both directions
        ch0_data = 12'h100; ch1_data = 12'h300;
        frame(0, 1'b0, 1'b0, 1'b1, 13, 1'b0, 12'h0, 1'b1);
        frame(0, 1'b0, 1'b1, 1'b1, 13, 1'b0, 12'h0, 1'b1);

        // LSB-first tail
        ch0_data = 12'h801;
        frame(0, 1'b1, 1'b0, 1'b0, 24, 1'b0, 12'h0, 1'b1);

        // abort after 6 data bits, then a clean frame
        ch0_data = 12'hA5C;
        frame(0, 1'b1, 1'b0, 1'b1, 7, 1'b0, 12'h0, 1'b1);
        frame(0, 1'b1, 1'b0, 1'b1, 13, 1'b0, 12'h0, 1'b1);

        // two leading zeros before the start bit
        ch1_data = 12'h5A3;
        frame(2, 1'b1, 1'b1, 1'b1, 13, 1'b0, 12'h0, 1'b1);

        // reset during MSB with cs held low through release
        frame(0, 1'b1, 1'b0, 1'b1, 5, 1'b0, 12'h0, 1'b0);
        rst_n = 1'b0;
        exp_cnt = 0;
        repeat (2) @(posedge clk); #1;
        lit("midreset_outputs", int'({miso, miso_oe, cfg_sgl, cfg_odd, cfg_msbf, frame_done, frame_abort}), 0);
        lit("midreset_frame_cnt", int'(frame_cnt), 0);
        rst_n = 1'b1;
        repeat (6) sck_cycle(1'b1, 1'b0, 1'b0);
        lit("no_frame_after_reset", int'(frame_cnt), 0);
        cs = 1'b1;
        repeat (8) @(posedge clk); #1;
        ch0_data = 12'h3C6;
        frame(0, 1'b1, 1'b0, 1'b1, 13, 1'b0, 12'h0, 1'b1);

        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
